// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the CPU datapath and a
// word-wide memory bus. It classifies each request, runs one bus transaction
// with byte enables and replicated store data, extracts and extends load data,
// and reports misaligned, illegal and timed-out accesses as a one-cycle fault.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size_in,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BAD  = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [1:0] FC_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       size_reg, size_next;
  logic [1:0]       lane_reg, lane_next;
  logic             uns_reg, uns_next;
  logic             bus_req_reg, bus_req_next;
  logic             bus_we_reg, bus_we_next;
  logic [31:0]      bus_addr_reg, bus_addr_next;
  logic [3:0]       bus_be_reg, bus_be_next;
  logic [31:0]      bus_wdata_reg, bus_wdata_next;
  logic [31:0]      rdata_reg, rdata_next;
  logic             fault_reg, fault_next;
  logic [1:0]       fault_code_reg, fault_code_next;

  logic        request;
  logic        req_illegal;
  logic        req_misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_lanes;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  genvar gi;

  assign request        = mem_read | mem_write;
  assign req_illegal    = (size_in == SZ_BAD) | (mem_read & mem_write);
  assign req_misaligned = ((size_in == SZ_HALF) & addr[0]) |
                          ((size_in == SZ_WORD) & (addr[1:0] != 2'b00));

  // Stall holds the pipeline from the request cycle until the bus completes.
  assign stall = ~reset & (((state_reg == IDLE) & request) | (state_reg == BUS));

  // Byte enables for a store, positioned at the addressed lane.
  always_comb begin
    be_calc = 4'b1111;
    case (size_in)
      SZ_BYTE: be_calc = 4'b0001 << addr[1:0];
      SZ_HALF: be_calc = 4'b0011 << addr[1:0];
      default: be_calc = 4'b1111;
    endcase
  end

  // Store data is replicated across lanes so the enabled lanes carry the
  // right bytes regardless of address offset.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_store_lane
      assign wdata_lanes[gi*8 +: 8] =
        (size_in == SZ_BYTE) ? wdata[7:0] :
        (size_in == SZ_HALF) ? wdata[(gi%2)*8 +: 8] :
                               wdata[gi*8 +: 8];
    end
  endgenerate

  // Load data: shift the addressed lane down, then sign- or zero-extend.
  assign shifted = bus_rdata >> {lane_reg, 3'b000};

  always_comb begin
    load_ext = bus_rdata;
    case (size_reg)
      SZ_BYTE: load_ext = {{24{~uns_reg & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_ext = {{16{~uns_reg & shifted[15]}}, shifted[15:0]};
      default: load_ext = bus_rdata;
    endcase
  end

  // Next-state and next-output logic for IDLE -> BUS -> DONE sequencing.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    size_next       = size_reg;
    lane_next       = lane_reg;
    uns_next        = uns_reg;
    bus_req_next    = bus_req_reg;
    bus_we_next     = bus_we_reg;
    bus_addr_next   = bus_addr_reg;
    bus_be_next     = bus_be_reg;
    bus_wdata_next  = bus_wdata_reg;
    rdata_next      = 32'h0;
    fault_next      = 1'b0;
    fault_code_next = 2'b00;

    case (state_reg)
      IDLE: begin
        if (request) begin
          if (req_illegal) begin
            state_next      = DONE;
            fault_next      = 1'b1;
            fault_code_next = FC_ILLEGAL;
          end else if (req_misaligned) begin
            state_next      = DONE;
            fault_next      = 1'b1;
            fault_code_next = FC_MISALIGN;
          end else begin
            state_next     = BUS;
            cnt_next       = CNT_W'(1);
            size_next      = size_in;
            lane_next      = addr[1:0];
            uns_next       = load_unsigned;
            bus_req_next   = 1'b1;
            bus_we_next    = mem_write;
            bus_addr_next  = {addr[31:2], 2'b00};
            bus_be_next    = mem_write ? be_calc : 4'b0000;
            bus_wdata_next = mem_write ? wdata_lanes : 32'h0;
          end
        end
      end

      BUS: begin
        if (bus_ack || (cnt_reg == CNT_LIMIT)) begin
          state_next     = DONE;
          cnt_next       = '0;
          bus_req_next   = 1'b0;
          bus_we_next    = 1'b0;
          bus_addr_next  = 32'h0;
          bus_be_next    = 4'b0000;
          bus_wdata_next = 32'h0;
          if (bus_ack) begin
            rdata_next = bus_we_reg ? 32'h0 : load_ext;
          end else begin
            fault_next      = 1'b1;
            fault_code_next = FC_TIMEOUT;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and registered outputs, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      size_reg       <= 2'b00;
      lane_reg       <= 2'b00;
      uns_reg        <= 1'b0;
      bus_req_reg    <= 1'b0;
      bus_we_reg     <= 1'b0;
      bus_addr_reg   <= 32'h0;
      bus_be_reg     <= 4'b0000;
      bus_wdata_reg  <= 32'h0;
      rdata_reg      <= 32'h0;
      fault_reg      <= 1'b0;
      fault_code_reg <= 2'b00;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      size_reg       <= size_next;
      lane_reg       <= lane_next;
      uns_reg        <= uns_next;
      bus_req_reg    <= bus_req_next;
      bus_we_reg     <= bus_we_next;
      bus_addr_reg   <= bus_addr_next;
      bus_be_reg     <= bus_be_next;
      bus_wdata_reg  <= bus_wdata_next;
      rdata_reg      <= rdata_next;
      fault_reg      <= fault_next;
      fault_code_reg <= fault_code_next;
    end
  end

  assign bus_req    = bus_req_reg;
  assign bus_we     = bus_we_reg;
  assign bus_addr   = bus_addr_reg;
  assign bus_be     = bus_be_reg;
  assign bus_wdata  = bus_wdata_reg;
  assign rdata      = rdata_reg;
  assign fault      = fault_reg;
  assign fault_code = fault_code_reg;

endmodule
